// File: rtl/axi_rd_rr_arbiter.sv
// axi_rd_rr_arbiter: shares one AXI4 read port (AR/R) between NumPorts requesters.
// AR requests are granted round-robin into a single output register and the
// port index is prefixed onto the master-side ID. R beats are routed back by
// that prefix. Per-port credit counters cap outstanding bursts at MaxTxns.
// Optional build macro AXI_RD_RR_ARBITER_PERF_EN adds grant/stall counters.

// Per-port outstanding-burst credit counter.
module axi_rd_rr_credit #(
  parameter int MaxTxns  = 8,
  parameter int CntWidth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_avail,
  output logic o_nz_nxt
);
  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] w_cnt_nxt;

  // Simultaneous issue and retire cancel; saturate at both ends.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_inc && !i_dec && r_cnt != CntWidth'(MaxTxns))
      w_cnt_nxt = r_cnt + 1'b1;
    else if (i_dec && !i_inc && r_cnt != '0)
      w_cnt_nxt = r_cnt - 1'b1;
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_cnt <= '0;
    else         r_cnt <= w_cnt_nxt;
  end

  assign o_avail  = (r_cnt < CntWidth'(MaxTxns));
  assign o_nz_nxt = |w_cnt_nxt;
endmodule

module axi_rd_rr_arbiter #(
  parameter int NumPorts  = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64,
  parameter int IdWidth   = 4,
  parameter int MaxTxns   = 8,
  localparam int IdxWidth = $clog2(NumPorts),
  localparam int MstIdW   = IdWidth + IdxWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumPorts-1:0]           slv_ar_valid_i,
  output logic [NumPorts-1:0]           slv_ar_ready_o,
  input  logic [NumPorts*AddrWidth-1:0] slv_ar_addr_i,
  input  logic [NumPorts*8-1:0]         slv_ar_len_i,
  input  logic [NumPorts*IdWidth-1:0]   slv_ar_id_i,
  output logic [NumPorts-1:0]           slv_r_valid_o,
  input  logic [NumPorts-1:0]           slv_r_ready_i,
  output logic [DataWidth-1:0]          slv_r_data_o,
  output logic [IdWidth-1:0]            slv_r_id_o,
  output logic                          slv_r_last_o,
  output logic                          mst_ar_valid_o,
  input  logic                          mst_ar_ready_i,
  output logic [AddrWidth-1:0]          mst_ar_addr_o,
  output logic [7:0]                    mst_ar_len_o,
  output logic [MstIdW-1:0]             mst_ar_id_o,
  input  logic                          mst_r_valid_i,
  output logic                          mst_r_ready_o,
  input  logic [DataWidth-1:0]          mst_r_data_i,
  input  logic [MstIdW-1:0]             mst_r_id_i,
  input  logic                          mst_r_last_i,
  output logic                          busy_o
`ifdef AXI_RD_RR_ARBITER_PERF_EN
  ,
  output logic [NumPorts*32-1:0]        perf_grant_cnt_o,
  output logic [31:0]                   perf_stall_cnt_o
`endif
);
  localparam int CntWidth = $clog2(MaxTxns + 1);

  logic                 r_full;
  logic [AddrWidth-1:0] r_addr;
  logic [7:0]           r_len;
  logic [MstIdW-1:0]    r_id;
  logic [IdxWidth-1:0]  r_ptr;
  logic                 r_busy;

  logic                 w_load;
  logic                 w_found;
  logic [IdxWidth-1:0]  w_gnt;
  logic [IdxWidth-1:0]  w_ptr_nxt;
  logic                 w_full_nxt;
  logic [IdxWidth-1:0]  w_r_idx;
  logic [NumPorts-1:0]  w_avail;
  logic [NumPorts-1:0]  w_elig;
  logic [NumPorts-1:0]  w_inc;
  logic [NumPorts-1:0]  w_dec;
  logic [NumPorts-1:0]  w_nz_nxt;

  // The output register can take a new burst when empty or draining this cycle.
  assign w_load  = rst_ni && (!r_full || mst_ar_ready_i);
  assign w_elig  = slv_ar_valid_i & w_avail;
  assign w_r_idx = mst_r_id_i[IdWidth +: IdxWidth];

  // Round-robin search: first eligible port at or after the pointer.
  always_comb begin
    int w_p;
    w_p     = 0;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < NumPorts; i++) begin
      w_p = int'(r_ptr) + i;
      if (w_p >= NumPorts) w_p = w_p - NumPorts;
      if (!w_found && w_elig[w_p]) begin
        w_found = 1'b1;
        w_gnt   = IdxWidth'(w_p);
      end
    end
  end

  assign w_ptr_nxt  = (w_gnt == IdxWidth'(NumPorts - 1)) ? '0 : w_gnt + 1'b1;
  assign w_full_nxt = w_load ? w_found : r_full;

  // One-hot AR ready toward the granted requester.
  always_comb begin
    slv_ar_ready_o = '0;
    if (w_load && w_found) slv_ar_ready_o[w_gnt] = 1'b1;
  end

  // R steering by ID prefix; beats with an unmapped prefix are sunk.
  always_comb begin
    slv_r_valid_o = '0;
    mst_r_ready_o = 1'b1;
    for (int p = 0; p < NumPorts; p++) begin
      if (w_r_idx == IdxWidth'(p)) begin
        slv_r_valid_o[p] = mst_r_valid_i;
        mst_r_ready_o    = slv_r_ready_i[p];
      end
    end
  end

  assign slv_r_data_o = mst_r_data_i;
  assign slv_r_id_o   = mst_r_id_i[IdWidth-1:0];
  assign slv_r_last_o = mst_r_last_i;

  // Ready is only raised for an eligible (hence valid) port, so it marks the handshake.
  assign w_inc = slv_ar_ready_o;
  assign w_dec = slv_r_valid_o & slv_r_ready_i & {NumPorts{mst_r_last_i}};

  for (genvar g = 0; g < NumPorts; g++) begin : g_credit
    axi_rd_rr_credit #(.MaxTxns(MaxTxns), .CntWidth(CntWidth)) u_credit (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .i_inc    (w_inc[g]),
      .i_dec    (w_dec[g]),
      .o_avail  (w_avail[g]),
      .o_nz_nxt (w_nz_nxt[g])
    );
  end

  // AR output register and round-robin pointer; holds stable while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_full <= 1'b0;
      r_addr <= '0;
      r_len  <= '0;
      r_id   <= '0;
      r_ptr  <= '0;
    end else if (w_load) begin
      r_full <= w_found;
      if (w_found) begin
        r_addr <= slv_ar_addr_i[int'(w_gnt)*AddrWidth +: AddrWidth];
        r_len  <= slv_ar_len_i[int'(w_gnt)*8 +: 8];
        r_id   <= {w_gnt, slv_ar_id_i[int'(w_gnt)*IdWidth +: IdWidth]};
        r_ptr  <= w_ptr_nxt;
      end
    end
  end

  // Busy tracks next-state occupancy so it lines up with the registered state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_busy <= 1'b0;
    else         r_busy <= w_full_nxt | (|w_nz_nxt);
  end

  assign mst_ar_valid_o = r_full;
  assign mst_ar_addr_o  = r_addr;
  assign mst_ar_len_o   = r_len;
  assign mst_ar_id_o    = r_id;
  assign busy_o         = r_busy;

`ifdef AXI_RD_RR_ARBITER_PERF_EN
  logic [NumPorts-1:0][31:0] r_grant_cnt;
  logic [31:0]               r_stall_cnt;

  // Per-port grant counters and master-side stall counter, free-running with wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++)
        if (slv_ar_ready_o[p]) r_grant_cnt[p] <= r_grant_cnt[p] + 32'd1;
      if (r_full && !mst_ar_ready_i) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  for (genvar g = 0; g < NumPorts; g++) begin : g_perf
    assign perf_grant_cnt_o[g*32 +: 32] = r_grant_cnt[g];
  end
  assign perf_stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_axi_rd_rr_arbiter.sv
// Bench for axi_rd_rr_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration/credit rules.
module tb_axi_rd_rr_arbiter;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int MT = 8;
  localparam int MW = IW + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    ar_valid, ar_ready, s_r_valid, s_r_ready;
  logic [NP*AW-1:0] ar_addr;
  logic [NP*8-1:0]  ar_len;
  logic [NP*IW-1:0] ar_id;
  logic [DW-1:0]    s_r_data, m_r_data;
  logic [IW-1:0]    s_r_id;
  logic             s_r_last, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last, busy;
  logic [AW-1:0]    m_ar_addr;
  logic [7:0]       m_ar_len;
  logic [MW-1:0]    m_ar_id, m_r_id;

  // Three-port instance for the unmapped-prefix case.
  logic [2:0]       t3_ar_valid, t3_ar_ready, t3_s_r_valid, t3_s_r_ready;
  logic [3*AW-1:0]  t3_ar_addr;
  logic [3*8-1:0]   t3_ar_len;
  logic [3*IW-1:0]  t3_ar_id;
  logic [DW-1:0]    t3_s_r_data;
  logic [IW-1:0]    t3_s_r_id;
  logic             t3_s_r_last, t3_m_ar_valid, t3_m_ar_ready, t3_m_r_valid, t3_m_r_ready, t3_m_r_last, t3_busy;
  logic [AW-1:0]    t3_m_ar_addr;
  logic [7:0]       t3_m_ar_len;
  logic [MW-1:0]    t3_m_ar_id, t3_m_r_id;

`ifdef AXI_RD_RR_ARBITER_PERF_EN
  logic [NP*32-1:0] perf_grant, t3_perf_grant_unused_w;
  logic [31:0]      perf_stall, t3_perf_stall;
  logic [3*32-1:0]  t3_perf_grant;
`endif

  axi_rd_rr_arbiter #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MaxTxns(MT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_ar_valid_i(ar_valid), .slv_ar_ready_o(ar_ready), .slv_ar_addr_i(ar_addr),
    .slv_ar_len_i(ar_len), .slv_ar_id_i(ar_id),
    .slv_r_valid_o(s_r_valid), .slv_r_ready_i(s_r_ready), .slv_r_data_o(s_r_data),
    .slv_r_id_o(s_r_id), .slv_r_last_o(s_r_last),
    .mst_ar_valid_o(m_ar_valid), .mst_ar_ready_i(m_ar_ready), .mst_ar_addr_o(m_ar_addr),
    .mst_ar_len_o(m_ar_len), .mst_ar_id_o(m_ar_id),
    .mst_r_valid_i(m_r_valid), .mst_r_ready_o(m_r_ready), .mst_r_data_i(m_r_data),
    .mst_r_id_i(m_r_id), .mst_r_last_i(m_r_last), .busy_o(busy)
`ifdef AXI_RD_RR_ARBITER_PERF_EN
    , .perf_grant_cnt_o(perf_grant), .perf_stall_cnt_o(perf_stall)
`endif
  );

  axi_rd_rr_arbiter #(.NumPorts(3), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MaxTxns(MT)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_ar_valid_i(t3_ar_valid), .slv_ar_ready_o(t3_ar_ready), .slv_ar_addr_i(t3_ar_addr),
    .slv_ar_len_i(t3_ar_len), .slv_ar_id_i(t3_ar_id),
    .slv_r_valid_o(t3_s_r_valid), .slv_r_ready_i(t3_s_r_ready), .slv_r_data_o(t3_s_r_data),
    .slv_r_id_o(t3_s_r_id), .slv_r_last_o(t3_s_r_last),
    .mst_ar_valid_o(t3_m_ar_valid), .mst_ar_ready_i(t3_m_ar_ready), .mst_ar_addr_o(t3_m_ar_addr),
    .mst_ar_len_o(t3_m_ar_len), .mst_ar_id_o(t3_m_ar_id),
    .mst_r_valid_i(t3_m_r_valid), .mst_r_ready_o(t3_m_r_ready), .mst_r_data_i(m_r_data),
    .mst_r_id_i(t3_m_r_id), .mst_r_last_i(t3_m_r_last), .busy_o(t3_busy)
`ifdef AXI_RD_RR_ARBITER_PERF_EN
    , .perf_grant_cnt_o(t3_perf_grant), .perf_stall_cnt_o(t3_perf_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state: pointer, per-port outstanding counts, AR register.
  int            m_ptr;
  int            m_cnt[NP];
  bit            m_full;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_len;
  logic [MW-1:0] m_id;
  bit            m_busy;
  // Model expectations for the current cycle.
  int            e_gnt;
  bit            e_load;
  logic [NP-1:0] e_ar_ready, e_r_valid;
  logic          e_r_ready;

  task automatic model_comb();
    int p, rp;
    e_load = rst_n && (!m_full || m_ar_ready);
    e_gnt  = -1;
    for (int i = 0; i < NP; i++) begin
      p = (m_ptr + i) % NP;
      if (e_gnt < 0 && ar_valid[p] && m_cnt[p] < MT) e_gnt = p;
    end
    e_ar_ready = '0;
    if (e_load && e_gnt >= 0) e_ar_ready[e_gnt] = 1'b1;
    rp = int'(m_r_id) / (1 << IW);
    e_r_valid = '0;
    e_r_ready = 1'b1;
    if (rp < NP) begin
      e_r_valid[rp] = m_r_valid;
      e_r_ready     = s_r_ready[rp];
    end
  endtask

  task automatic model_seq();
    bit inc, dec;
    if (!rst_n) return;
    for (int p = 0; p < NP; p++) begin
      inc = e_ar_ready[p];
      dec = e_r_valid[p] && s_r_ready[p] && m_r_last;
      if (inc && !dec) m_cnt[p]++;
      else if (dec && !inc && m_cnt[p] > 0) m_cnt[p]--;
    end
    if (e_load) begin
      if (e_gnt >= 0) begin
        m_full = 1'b1;
        m_addr = ar_addr[e_gnt*AW +: AW];
        m_len  = ar_len[e_gnt*8 +: 8];
        m_id   = MW'((e_gnt << IW) | int'(ar_id[e_gnt*IW +: IW]));
        m_ptr  = (e_gnt + 1) % NP;
      end else begin
        m_full = 1'b0;
      end
    end
    m_busy = m_full;
    for (int p = 0; p < NP; p++) if (m_cnt[p] != 0) m_busy = 1'b1;
  endtask

  // One clock: evaluate model with current inputs, advance on the edge, sample 1ns later.
  task automatic tick();
    model_comb();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic clear_inputs();
    ar_valid = '0; ar_addr = '0; ar_len = '0; ar_id = '0;
    s_r_ready = '0; m_ar_ready = 1'b0;
    m_r_valid = 1'b0; m_r_data = '0; m_r_id = '0; m_r_last = 1'b0;
    t3_ar_valid = '0; t3_ar_addr = '0; t3_ar_len = '0; t3_ar_id = '0;
    t3_s_r_ready = '0; t3_m_ar_ready = 1'b0;
    t3_m_r_valid = 1'b0; t3_m_r_id = '0; t3_m_r_last = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    m_ptr = 0; m_full = 1'b0; m_addr = '0; m_len = '0; m_id = '0; m_busy = 1'b0;
    for (int p = 0; p < NP; p++) m_cnt[p] = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    ar_valid = '1;
    m_r_valid = 1'b1;
    m_r_id = 6'h21;
    #3;
    checks++; if (ar_ready !== 4'b0000) begin errors++; $display("FAIL reset_ar_ready: got %b exp 0000", ar_ready); end
    checks++; if (m_ar_valid !== 1'b0) begin errors++; $display("FAIL reset_ar_valid: got %b exp 0", m_ar_valid); end
    checks++; if ({m_ar_addr, m_ar_len, m_ar_id} !== '0) begin errors++; $display("FAIL reset_ar_payload: got %h/%h/%h exp 0", m_ar_addr, m_ar_len, m_ar_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (s_r_valid !== 4'b0100) begin errors++; $display("FAIL reset_r_follow: got %b exp 0100", s_r_valid); end
    m_r_valid = 1'b0;
    #1;
    checks++; if (s_r_valid !== 4'b0000) begin errors++; $display("FAIL reset_r_idle: got %b exp 0000", s_r_valid); end
  endtask

  task automatic test_two_port();
    do_reset();
    m_ar_ready = 1'b1;
    ar_valid = 4'b0101;
    ar_id = 16'h0301;
    ar_addr[0*AW +: AW] = 32'h1000_0000;
    ar_addr[2*AW +: AW] = 32'h2000_0000;
    #1;
    checks++; if (ar_ready !== 4'b0001) begin errors++; $display("FAIL two_port_g0: got %b exp 0001", ar_ready); end
    tick();
    checks++; if (m_ar_valid !== 1'b1 || m_ar_id !== 6'h01 || m_ar_addr !== 32'h1000_0000)
      begin errors++; $display("FAIL two_port_ar0: got v=%b id=%h a=%h exp v=1 id=01 a=10000000", m_ar_valid, m_ar_id, m_ar_addr); end
    ar_valid = 4'b0100;
    #1;
    checks++; if (ar_ready !== 4'b0100) begin errors++; $display("FAIL two_port_g2: got %b exp 0100", ar_ready); end
    tick();
    checks++; if (m_ar_valid !== 1'b1 || m_ar_id !== 6'h23 || m_ar_addr !== 32'h2000_0000)
      begin errors++; $display("FAIL two_port_ar2: got v=%b id=%h a=%h exp v=1 id=23 a=20000000", m_ar_valid, m_ar_id, m_ar_addr); end
    ar_valid = 4'b1111;
    #1;
    checks++; if (ar_ready !== 4'b1000) begin errors++; $display("FAIL two_port_ptr3: got %b exp 1000", ar_ready); end
    ar_valid = '0;
    tick();
  endtask

  task automatic test_rr_all();
    logic [NP-1:0] exp_rdy;
    logic [1:0]    exp_idx;
    do_reset();
    m_ar_ready = 1'b1;
    ar_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      exp_rdy = NP'(1 << (c % NP));
      exp_idx = 2'(c % NP);
      #1;
      checks++; if (ar_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant[%0d]: got %b exp %b", c, ar_ready, exp_rdy); end
      tick();
      checks++; if (m_ar_valid !== 1'b1 || m_ar_id[MW-1:IW] !== exp_idx)
        begin errors++; $display("FAIL rr_ar[%0d]: got v=%b idx=%0d exp v=1 idx=%0d", c, m_ar_valid, m_ar_id[MW-1:IW], exp_idx); end
    end
    ar_valid = '0;
    tick();
  endtask

  task automatic test_stall();
    logic [AW-1:0] sa;
    logic [7:0]    sl;
    do_reset();
    ar_valid = 4'b0010;
    ar_addr = {$urandom, $urandom, $urandom, $urandom};
    ar_len = $urandom;
    ar_id = 16'h00a0;
    m_ar_ready = 1'b0;
    sa = ar_addr[AW +: AW];
    sl = ar_len[8 +: 8];
    #1;
    checks++; if (ar_ready !== 4'b0010) begin errors++; $display("FAIL stall_load: got %b exp 0010", ar_ready); end
    tick();
    ar_addr = ~ar_addr;
    ar_len = ~ar_len;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (ar_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d]: got %b exp 0000", c, ar_ready); end
      tick();
      checks++; if (m_ar_valid !== 1'b1 || m_ar_addr !== sa || m_ar_len !== sl || m_ar_id !== 6'h1a)
        begin errors++; $display("FAIL stall_hold[%0d]: got v=%b a=%h l=%h id=%h exp v=1 a=%h l=%h id=1a", c, m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, sa, sl); end
    end
    m_ar_ready = 1'b1;
    #1;
    checks++; if (ar_ready !== 4'b0010) begin errors++; $display("FAIL stall_refill: got %b exp 0010", ar_ready); end
    ar_valid = '0;
    tick();
  endtask

  task automatic test_credit();
    do_reset();
    m_ar_ready = 1'b1;
    s_r_ready = 4'b1111;
    ar_valid = 4'b0010;
    for (int c = 0; c < MT; c++) begin
      #1;
      checks++; if (ar_ready !== 4'b0010) begin errors++; $display("FAIL credit_grant[%0d]: got %b exp 0010", c, ar_ready); end
      tick();
    end
    m_r_valid = 1'b1; m_r_id = 6'h17; m_r_last = 1'b1;
    #1;
    checks++; if (ar_ready !== 4'b0000) begin errors++; $display("FAIL credit_block: got %b exp 0000", ar_ready); end
    tick();
    m_r_valid = 1'b0; m_r_last = 1'b0;
    #1;
    checks++; if (ar_ready !== 4'b0010) begin errors++; $display("FAIL credit_return: got %b exp 0010", ar_ready); end
    ar_valid = '0;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL credit_busy: got %b exp 1", busy); end
  endtask

  task automatic test_r_route();
    logic [DW-1:0] d;
    do_reset();
    d = {$urandom, $urandom};
    m_r_data = d;
    s_r_ready = 4'b0111;
    m_r_valid = 1'b1; m_r_id = 6'h35; m_r_last = 1'b0;
    #1;
    checks++; if (m_r_ready !== 1'b0 || s_r_valid !== 4'b1000 || s_r_id !== 4'h5 || s_r_data !== d)
      begin errors++; $display("FAIL route_p3: got rdy=%b v=%b id=%h d=%h exp rdy=0 v=1000 id=5 d=%h", m_r_ready, s_r_valid, s_r_id, s_r_data, d); end
    tick();
    m_r_id = 6'h02; m_r_last = 1'b1;
    #1;
    checks++; if (m_r_ready !== 1'b1 || s_r_valid !== 4'b0001 || s_r_id !== 4'h2 || s_r_last !== 1'b1)
      begin errors++; $display("FAIL route_p0: got rdy=%b v=%b id=%h l=%b exp rdy=1 v=0001 id=2 l=1", m_r_ready, s_r_valid, s_r_id, s_r_last); end
    tick();
    m_r_valid = 1'b0; m_r_last = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL route_spurious_busy: got %b exp 0", busy); end
  endtask

  task automatic test_np3_drop();
    do_reset();
    t3_m_ar_ready = 1'b1;
    t3_s_r_ready = 3'b111;
    t3_ar_valid = 3'b001;
    @(posedge clk); #1;
    t3_ar_valid = 3'b000;
    checks++; if (t3_busy !== 1'b1) begin errors++; $display("FAIL np3_busy_grant: got %b exp 1", t3_busy); end
    t3_m_r_valid = 1'b1; t3_m_r_id = 6'h31; t3_m_r_last = 1'b1;
    #1;
    checks++; if (t3_m_r_ready !== 1'b1 || t3_s_r_valid !== 3'b000)
      begin errors++; $display("FAIL np3_drop: got rdy=%b v=%b exp rdy=1 v=000", t3_m_r_ready, t3_s_r_valid); end
    @(posedge clk); #1;
    checks++; if (t3_busy !== 1'b1) begin errors++; $display("FAIL np3_cnt_kept: got busy=%b exp 1", t3_busy); end
    t3_m_r_id = 6'h01;
    #1;
    checks++; if (t3_s_r_valid !== 3'b001) begin errors++; $display("FAIL np3_route0: got %b exp 001", t3_s_r_valid); end
    @(posedge clk); #1;
    t3_m_r_valid = 1'b0; t3_m_r_last = 1'b0;
    checks++; if (t3_busy !== 1'b0) begin errors++; $display("FAIL np3_cnt_ret: got busy=%b exp 0", t3_busy); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      ar_valid   = NP'($urandom);
      ar_addr    = {$urandom, $urandom, $urandom, $urandom};
      ar_len     = $urandom;
      ar_id      = 16'($urandom);
      m_ar_ready = ($urandom_range(3) != 0);
      m_r_valid  = $urandom_range(1);
      m_r_id     = MW'($urandom);
      m_r_last   = $urandom_range(1);
      m_r_data   = {$urandom, $urandom};
      s_r_ready  = NP'($urandom);
      #1;
      model_comb();
      checks++; if (ar_ready !== e_ar_ready) begin errors++; $display("FAIL rnd_ar_ready[%0d]: got %b exp %b", c, ar_ready, e_ar_ready); end
      checks++; if (s_r_valid !== e_r_valid || m_r_ready !== e_r_ready)
        begin errors++; $display("FAIL rnd_r_route[%0d]: got v=%b rdy=%b exp v=%b rdy=%b", c, s_r_valid, m_r_ready, e_r_valid, e_r_ready); end
      checks++; if (s_r_id !== m_r_id[IW-1:0] || s_r_data !== m_r_data || s_r_last !== m_r_last)
        begin errors++; $display("FAIL rnd_r_pass[%0d]: got id=%h l=%b exp id=%h l=%b", c, s_r_id, s_r_last, m_r_id[IW-1:0], m_r_last); end
      tick();
      checks++; if (m_ar_valid !== m_full || busy !== m_busy)
        begin errors++; $display("FAIL rnd_state[%0d]: got v=%b busy=%b exp v=%b busy=%b", c, m_ar_valid, busy, m_full, m_busy); end
      if (m_full) begin
        checks++; if (m_ar_addr !== m_addr || m_ar_len !== m_len || m_ar_id !== m_id)
          begin errors++; $display("FAIL rnd_ar[%0d]: got a=%h l=%h id=%h exp a=%h l=%h id=%h", c, m_ar_addr, m_ar_len, m_ar_id, m_addr, m_len, m_id); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_port();
    test_rr_all();
    test_stall();
    test_credit();
    test_r_route();
    test_np3_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: run did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/axi_rd_rr_arbiter.md
Name: axi_rd_rr_arbiter

Overview:
- Shares one AXI4 read port (AR/R only) between NumPorts requesters, e.g. GPU compute-unit fetch engines feeding one simulation or real memory.
- Grants AR requests round-robin and prefixes the port index onto the transaction ID.
- Routes R beats back by ID prefix.
- Caps outstanding bursts per port with credit counters.

Parameters:
- NumPorts, 4, number of requester ports (>=2).
- AddrWidth, 32, address width.
- DataWidth, 64, R data width.
- IdWidth, 4, requester-side ID width. Master-side ID width is IdWidth+IdxWidth, with IdxWidth = $clog2(NumPorts).
- MaxTxns, 8, maximum outstanding AR bursts per port (>=1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- slv_ar_valid_i  in  NumPorts  per-port AR valid.
- slv_ar_ready_o  out  NumPorts  per-port AR ready.
- slv_ar_addr_i  in  NumPorts*AddrWidth  per-port AR address.
- slv_ar_len_i  in  NumPorts*8  per-port burst length.
- slv_ar_id_i  in  NumPorts*IdWidth  per-port AR ID.
- slv_r_valid_o  out  NumPorts  per-port R valid.
- slv_r_ready_i  in  NumPorts  per-port R ready.
- slv_r_data_o  out  DataWidth  R data, broadcast to all ports.
- slv_r_id_o  out  IdWidth  R ID low bits, broadcast.
- slv_r_last_o  out  1  R last, broadcast.
- mst_ar_valid_o  out  1  master AR valid.
- mst_ar_ready_i  in  1  master AR ready.
- mst_ar_addr_o  out  AddrWidth  master AR address.
- mst_ar_len_o  out  8  master AR length.
- mst_ar_id_o  out  IdWidth+IdxWidth  {port index, requester ID}.
- mst_r_valid_i  in  1  master R valid.
- mst_r_ready_o  out  1  master R ready.
- mst_r_data_i  in  DataWidth  master R data.
- mst_r_id_i  in  IdWidth+IdxWidth  master R ID.
- mst_r_last_i  in  1  master R last.
- busy_o  out  1  any outstanding burst.

Behaviour:
- Reset (async, rst_ni low):
  - AR register empty; mst_ar_valid_o=0; mst_ar_addr/len/id=0.
  - Round-robin pointer=0; all credit counters=0; busy_o=0.
  - slv_ar_ready_o=0. R path is combinational, so slv_r_valid_o follows inputs and is 0 while mst_r_valid_i=0.
- Eligibility: port p is eligible when slv_ar_valid_i[p]=1 and cnt[p]<MaxTxns.
- AR register states:
  - EMPTY: the register can load.
  - FULL with mst_ar_ready_i=1: the register can also load (same-cycle refill).
  - FULL with mst_ar_ready_i=0: the register holds and stays stable; payload and valid do not change until the handshake (AXI stability rule).
- Grant: when the register can load and any port is eligible:
  - Pick the first eligible port searching from ptr upward, wrapping at NumPorts.
  - Assert slv_ar_ready_o[g]=1 in that cycle (one-hot, combinational).
  - Latch addr, len and {g, id}; set ptr=g+1 mod NumPorts.
  - mst_ar_valid_o rises next cycle. AR latency is 1 cycle; sustained throughput is 1 AR per cycle.
- No eligible port: slv_ar_ready_o=0. The register empties after a handshake with no refill.
- R routing:
  - port=mst_r_id_i[IdWidth+:IdxWidth]; slv_r_valid_o[port]=mst_r_valid_i, all other ports 0; mst_r_ready_o=slv_r_ready_i[port].
  - slv_r_id_o=mst_r_id_i[IdWidth-1:0]; data and last pass through.
  - Index >= NumPorts (non-power-of-two NumPorts): mst_r_ready_o=1, beat dropped, no port valid.
- Credits:
  - cnt[p]+1 on slv AR handshake of p.
  - cnt[p]-1 on an R handshake with last for p.
  - Both in the same cycle: unchanged.
  - Counter width $clog2(MaxTxns+1); never exceeds MaxTxns, never underflows. A spurious last at cnt=0 leaves the counter at 0.
- busy_o: registered, 1 when any cnt!=0 or the AR register is FULL.
- Reset mid-burst: all state cleared immediately. The master-side transaction is abandoned; the system is reset together.

Optional Feature:
- Macro: AXI_RD_RR_ARBITER_PERF_EN.
- Defined:
  - Adds output perf_grant_cnt_o, NumPorts*32: per-port count of AR grants.
  - Adds output perf_stall_cnt_o, 32: cycles with mst_ar_valid_o=1 and mst_ar_ready_i=0.
  - Both counters reset to 0, increment by 1, and wrap at 2^32.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset, then ports 0 and 2 assert AR with ids 1 and 3 in the same cycle; mst_ar_ready_i=1 → port 0 is granted first with mst_ar_id_o={0,1}, then the next cycle port 2 with {2,3}. ptr ends at 3.
- All 4 ports continuously valid, master always ready, 8 cycles → grant order 0,1,2,3,0,1,2,3, one mst_ar_valid_o per cycle from cycle 1.
- Hold mst_ar_ready_i=0 for 5 cycles with a burst in the register → mst_ar_addr/len/id stay constant, slv_ar_ready_o=0.
- Port 1 issues 8 ARs with no R returned (MaxTxns=8) → the 9th request is not granted. R beat id={1,x} with last=1 → port 1 is granted in the following cycle.
- Interleaved R beats ids {3,5} and {0,2} with slv_r_ready_i[3]=0 → mst_r_ready_o=0 during the port-3 beat. slv_r_valid_o is one-hot on 3 and then on 0; slv_r_id_o shows 5 then 2.
- NumPorts=3, R beat with prefix 3 → mst_r_ready_o=1, no slv_r_valid_o asserted, all counters unchanged.
